// File: rtl/risc_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, stall, branch redirect and flush.
// Optional FETCH_TIMEOUT_EN adds a sticky fetch_err after TIMEOUT_CYCLES ack-less wait cycles.
module risc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] fetch_count,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] instr, instr_next;
    logic        valid, valid_next;
    logic [31:0] count, count_next;
    logic        pending, pending_next;
    logic [31:0] target_q, target_next;
    logic        waiting, waiting_next;
    logic [31:0] aligned;

`ifdef FETCH_TIMEOUT_EN
    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wait_cnt, wait_cnt_next;
    logic          err, err_next;
    assign fetch_err = err;
`else
    assign fetch_err = 1'b0;
`endif

    assign aligned     = branch_target & ~32'h3;
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign pc_out      = pc;
    assign instr_out   = instr;
    assign instr_valid = valid;
    assign fetch_count = count;

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        instr_next   = instr;
        valid_next   = 1'b0;
        count_next   = count;
        pending_next = pending;
        target_next  = target_q;
        waiting_next = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_next = '0;
        err_next      = err;
`endif
        case (state)
            IDLE: begin
                if (branch_valid) begin
                    pc_next    = aligned;
                    instr_next = NOP_INSTR;
                end else if (en && !stall) begin
                    state_next = FETCH;
                end
            end
            HOLD: begin
                if (branch_valid) begin
                    pc_next    = aligned;
                    instr_next = NOP_INSTR;
                    if (!stall && en) state_next = FETCH;
                end else if (!stall) begin
                    state_next = en ? FETCH : IDLE;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    // A live or remembered redirect turns this response into a flush.
                    if (branch_valid || pending) begin
                        pc_next      = branch_valid ? aligned : target_q;
                        instr_next   = NOP_INSTR;
                        pending_next = 1'b0;
                    end else begin
                        instr_next = imem_rdata;
                        valid_next = 1'b1;
                        pc_next    = pc + 32'd4;
                        count_next = count + 32'd1;
                    end
                    state_next = stall ? HOLD : (en ? FETCH : IDLE);
                end else begin
                    if (branch_valid) begin
                        if (waiting) begin
                            pending_next = 1'b1;
                            target_next  = aligned;
                        end else begin
                            pc_next    = aligned;
                            instr_next = NOP_INSTR;
                        end
                    end
                    // A first-cycle redirect restarts the request at the new address.
                    waiting_next = waiting || !branch_valid;
`ifdef FETCH_TIMEOUT_EN
                    if (wait_cnt == TO_LAST) begin
                        err_next     = 1'b1;
                        state_next   = IDLE;
                        waiting_next = 1'b0;
                    end else begin
                        wait_cnt_next = wait_cnt + 1'b1;
                    end
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
            count    <= 32'd0;
            pending  <= 1'b0;
            target_q <= 32'd0;
            waiting  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
            err      <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            instr    <= instr_next;
            valid    <= valid_next;
            count    <= count_next;
            pending  <= pending_next;
            target_q <= target_next;
            waiting  <= waiting_next;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= wait_cnt_next;
            err      <= err_next;
`endif
        end
    end

endmodule

// File: doc/risc_fetch_unit.md
Name: risc_fetch_unit

Overview:
Instruction fetch stage of the RISC CPU. It sits directly upstream of the 32-bit instruction register.
- Holds the program counter (PC) and issues word requests to instruction memory over a req/ack handshake.
- Presents each fetched word on instr_out. The downstream register samples instr_out every clock.
- Handles stall, branch redirect/flush and PC wrap-around.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, word driven on instr_out after reset and after a flush.
TIMEOUT_CYCLES, 255, maximum wait cycles for imem_ack (used only with the optional feature).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  fetch enable.
stall  input  1  downstream stall; freezes instr_out and blocks new requests.
branch_valid  input  1  redirect request, one-cycle pulse.
branch_target  input  32  redirect address; bits [1:0] are forced to 0.
imem_req  output  1  memory request.
imem_addr  output  32  request address, always equal to pc_out.
imem_ack  input  1  memory response valid.
imem_rdata  input  32  memory response data, valid when imem_ack=1.
instr_out  output  32  fetched instruction, registered.
instr_valid  output  1  one-cycle pulse when instr_out is updated with a new fetched word.
pc_out  output  32  current PC.
fetch_count  output  32  number of accepted instructions; wraps modulo 2^32.
fetch_err  output  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - pc = RESET_PC, state = IDLE.
  - imem_req = 0, instr_out = NOP_INSTR, instr_valid = 0.
  - fetch_count = 0, fetch_err = 0, redirect_pending = 0.
  - rst asserted mid-request drops imem_req on the next edge; any late ack is ignored.
- Priority within a cycle: rst > branch_valid > imem_ack > stall > en.
- States:
  - IDLE:
    - imem_req = 0.
    - en=1 and stall=0 -> FETCH.
  - FETCH:
    - imem_req = 1, imem_addr = pc.
    - imem_req is held and imem_addr is stable until imem_ack.
    - On ack with no redirect:
      - instr_out <= imem_rdata, instr_valid <= 1.
      - pc <= pc + 4; fetch_count <= fetch_count + 1.
    - Next state after ack: HOLD if stall=1, else FETCH if en=1, else IDLE.
    - Back-to-back fetch sustains 1 instruction per cycle when ack returns in the same cycle as req.
  - HOLD:
    - imem_req = 0, instr_out is held, instr_valid = 0.
    - When stall=0: FETCH if en=1, else IDLE.
- Latency: instr_out updates on the clock edge that samples imem_ack. instr_valid is high for exactly that one following cycle.
- en=0 during FETCH: the outstanding request completes normally, then the block goes to IDLE.
- Branch with no request outstanding (IDLE/HOLD, or FETCH on the cycle req first rises):
  - pc <= {branch_target[31:2], 2'b00}.
  - instr_out <= NOP_INSTR, instr_valid <= 0.
  - State is unchanged, except HOLD goes to FETCH when stall=0 and en=1.
- Branch while a FETCH request is waiting for ack:
  - Set redirect_pending.
  - The address stays stable until ack.
  - When ack arrives, the data is discarded (no instr_valid, no count increment), pc <= target, and a new request is issued next cycle.
- Branch in the same cycle as ack: data discarded; pc <= aligned target.
- A second branch while redirect_pending is set overwrites the stored target.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag. fetch_count wraps silently.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES: fetch_err <= 1 (sticky until rst), imem_req drops, state -> IDLE.
  - pc is unchanged, so the same address is re-requested if en remains 1.
- Undefined: no counter; FETCH waits indefinitely; fetch_err is constant 0.

Test Plan:
1. Reset release, en=1, memory acks every cycle with rdata = addr ^ 32'hA5A5_0000 -> imem_addr sequence 0,4,8,C; instr_out tracks each word one cycle later; instr_valid high 4 consecutive cycles; fetch_count = 4.
2. stall=1 for 3 cycles right after the word at 0x8 is accepted -> imem_req=0 and instr_out held for those 3 cycles; fetching resumes at 0xC on the cycle after stall falls.
3. branch_valid with target 0x0000_0103 while req to 0x10 waits 2 cycles for ack -> the 0x10 data is discarded with no instr_valid pulse; next request address is 0x100; fetch_count does not increment for the discarded word.
4. RESET_PC=32'hFFFF_FFF8, acks every cycle -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
5. rst pulsed while imem_req=1 and before ack -> next cycle imem_req=0, pc=RESET_PC, instr_out=NOP_INSTR; an ack arriving one cycle later is ignored.
6. With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never asserted -> fetch_err rises after 4 wait cycles and imem_req drops. Ack at cycle 3 instead -> fetch_err stays 0.
